// File: rtl/encoder_pkg.sv
// Shared constants and index type for the 4-to-2 pending encoder.
package encoder_pkg;
  localparam int unsigned N_REQ = 4;
  localparam int unsigned IDX_W = 2;

  typedef logic [IDX_W-1:0] idx_t;

  localparam idx_t RR_PTR_RST = 2'd3;
endpackage

// File: rtl/prio_pick_4.sv
// Combinational 4-way priority pick: highest set bit, or first set bit at/after start.
module prio_pick_4
  import encoder_pkg::*;
(
  input  logic [N_REQ-1:0] vec,
  input  idx_t             start,
  input  logic             rotate,
  output logic             found,
  output idx_t             idx,
  output logic [N_REQ-1:0] onehot
);

  idx_t k;

  always_comb begin
    found  = 1'b0;
    idx    = '0;
    k      = '0;
    onehot = '0;
    if (rotate) begin
      // Walk upward from start with natural 2-bit wrap; first hit wins.
      for (int unsigned i = 0; i < N_REQ; i++) begin
        k = start + IDX_W'(i);
        if (!found && vec[k]) begin
          found = 1'b1;
          idx   = k;
        end
      end
    end else begin
      // Ascending scan so the highest set bit is the last one kept.
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (vec[i]) begin
          found = 1'b1;
          idx   = IDX_W'(i);
        end
      end
    end
    if (found) begin
      onehot = N_REQ'(1) << idx;
    end
  end

endmodule

// File: rtl/encoder_4_2_pending.sv
// Registered 4-to-2 priority encoder with sticky pending bits and valid/ready output.
module encoder_4_2_pending
  import encoder_pkg::*;
#(
  parameter int unsigned ROUND_ROBIN = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             clr,
  input  logic             ready,
  output logic [IDX_W-1:0] y,
  output logic             valid,
  output logic [N_REQ-1:0] pend,
  output logic             multi,
  output logic             ovf
);

  idx_t             last;
  idx_t             start;
  idx_t             pick;
  logic             found;
  logic             load;
  logic [N_REQ-1:0] pick_oh;
  logic [N_REQ-1:0] take;
  logic [N_REQ-1:0] pend_nxt;
  logic             ovf_nxt;
  logic             multi_nxt;

  assign start = last + IDX_W'(1);

  prio_pick_4 u_pick (
    .vec    (pend),
    .start  (start),
    .rotate (ROUND_ROBIN != 0),
    .found  (found),
    .idx    (pick),
    .onehot (pick_oh)
  );

  // The output register may refill whenever it is empty or being consumed.
  always_comb begin
    load      = !valid || ready;
    take      = (load && found) ? pick_oh : '0;
    pend_nxt  = (pend & ~take) | req;
    ovf_nxt   = |(req & pend & ~take);
    multi_nxt = (pend_nxt & (pend_nxt - N_REQ'(1))) != '0;
  end

  // multi is registered from pend_nxt so it lines up with pend exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y     <= '0;
      valid <= 1'b0;
      pend  <= '0;
      multi <= 1'b0;
      ovf   <= 1'b0;
      last  <= RR_PTR_RST;
    end else if (clr) begin
      valid <= 1'b0;
      pend  <= '0;
      multi <= 1'b0;
      ovf   <= 1'b0;
      last  <= RR_PTR_RST;
    end else begin
      pend  <= pend_nxt;
      multi <= multi_nxt;
      ovf   <= ovf_nxt;
      if (load) begin
        if (found) begin
          y     <= pick;
          valid <= 1'b1;
          last  <= pick;
        end else begin
          valid <= 1'b0;
        end
      end
    end
  end

endmodule
